// File: rtl/staged_capture_pkg.sv
// rtl/staged_capture_pkg.sv - state encoding and sizing helper for staged_capture_bank
package staged_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a single-channel bank still has a pointer bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/capture_slice.sv
// rtl/capture_slice.sv - one channel: shadow register feeding a committed output register
module capture_slice #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic         commit_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_q      <= '0;
    end else begin
      if (load_en)   r_shadow <= d;
      if (commit_en) r_q      <= r_shadow;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/staged_capture_bank.sv
// rtl/staged_capture_bank.sv - capture channels into shadows, then commit them all at once
module staged_capture_bank
  import staged_capture_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int W       = 5,
  parameter int ORDERED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             commit,
  input  logic [NCH-1:0]   valid,
  input  logic [NCH*W-1:0] din,
  output logic [NCH*W-1:0] q,
  output logic [NCH-1:0]   staged_mask,
  output logic             busy,
  output logic             ready,
  output logic             done,
  output logic             q_valid,
  output logic             err
);

  localparam int            PW   = clog2_min1(NCH);
  localparam logic [PW-1:0] LAST = PW'(NCH - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PW-1:0]  r_ptr;
  logic [NCH-1:0] r_mask;
  logic           r_err;
  logic           r_done;
  logic           r_q_valid;

  logic [NCH-1:0] w_ptr_oh;
  logic [NCH-1:0] w_load;
  logic           w_hit;
  logic           w_start_seq;
  logic           w_mask_clr;
  logic           w_err_set;
  logic           w_commit_en;

  // one-hot of the pointer avoids indexing valid with a possibly wider pointer
  always_comb begin
    w_ptr_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ptr_oh[i] = (r_ptr == PW'(i));
    end
  end

  assign w_hit = |(valid & w_ptr_oh);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = '0;
    w_start_seq = 1'b0;
    w_mask_clr  = 1'b0;
    w_err_set   = 1'b0;
    w_commit_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CAPTURE;
          w_start_seq = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_mask_clr  = 1'b1;
        end else begin
          if (ORDERED != 0) begin
            w_load    = w_hit ? w_ptr_oh : '0;
            w_err_set = |(valid & ~w_ptr_oh);
          end else begin
            // first capture of a channel wins; repeats only raise the error flag
            w_load    = valid & ~r_mask;
            w_err_set = |(valid & r_mask);
          end
          if (&(r_mask | w_load)) w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_mask_clr  = 1'b1;
        end else if (commit) begin
          w_state_nxt = ST_IDLE;
          w_commit_en = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_mask    <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_q_valid <= 1'b0;
    end else begin
      if (w_start_seq) r_ptr <= '0;
      else if ((ORDERED != 0) && (|w_load) && (r_ptr != LAST)) r_ptr <= r_ptr + 1'b1;

      if (w_start_seq || w_mask_clr) r_mask <= '0;
      else                           r_mask <= r_mask | w_load;

      if (w_start_seq)    r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;

      r_done    <= w_commit_en;
      r_q_valid <= r_q_valid | w_commit_en;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slice
    capture_slice #(.W(W)) u_slice (
      .clk       (clk),
      .reset     (reset),
      .load_en   (w_load[g]),
      .commit_en (w_commit_en),
      .d         (din[g*W +: W]),
      .q         (q[g*W +: W])
    );
  end

  assign staged_mask = r_mask;
  assign busy        = (r_state != ST_IDLE);
  assign ready       = (r_state == ST_READY);
  assign done        = r_done;
  assign q_valid     = r_q_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_staged_capture_bank.sv
// tb/tb_staged_capture_bank.sv - scoreboard bench: ordered and unordered banks, NCH=3, W=5
module tb_staged_capture_bank;

  logic        clk;
  logic        reset;

  logic        start_a, abort_a, commit_a;
  logic [2:0]  valid_a;
  logic [14:0] din_a;
  logic [14:0] q_a;
  logic [2:0]  mask_a;
  logic        busy_a, ready_a, done_a, q_valid_a, err_a;

  logic        start_b, abort_b, commit_b;
  logic [2:0]  valid_b;
  logic [14:0] din_b;
  logic [14:0] q_b;
  logic [2:0]  mask_b;
  logic        busy_b, ready_b, done_b, q_valid_b, err_b;

  int          n_tests;
  int          n_fail;
  logic [14:0] exp_a[$];
  logic [14:0] exp_b[$];
  logic [14:0] e_a, e_b;

  staged_capture_bank #(.NCH(3), .W(5), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .commit(commit_a),
    .valid(valid_a), .din(din_a), .q(q_a), .staged_mask(mask_a), .busy(busy_a),
    .ready(ready_a), .done(done_a), .q_valid(q_valid_a), .err(err_a)
  );

  staged_capture_bank #(.NCH(3), .W(5), .ORDERED(0)) u_any (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .commit(commit_b),
    .valid(valid_b), .din(din_b), .q(q_b), .staged_mask(mask_b), .busy(busy_b),
    .ready(ready_b), .done(done_b), .q_valid(q_valid_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors: every done pulse must match the next queued commit value
  always @(negedge clk) begin
    if (done_a) begin
      chk("a_done_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) begin
        e_a = exp_a.pop_front();
        chk("a_q_on_done", 32'(q_a), 32'(e_a));
      end
    end
    if (done_b) begin
      chk("b_done_expected", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) begin
        e_b = exp_b.pop_front();
        chk("b_q_on_done", 32'(q_b), 32'(e_b));
      end
    end
  end

  task automatic cap_a(input int ch, input logic [4:0] data);
    valid_a         = 3'(1 << ch);
    din_a[ch*5 +: 5] = data;
    tick();
    valid_a = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    {start_a, abort_a, commit_a, valid_a, din_a} = '0;
    {start_b, abort_b, commit_b, valid_b, din_b} = '0;
    #12;
    chk("rst_q", 32'(q_a), 0);
    chk("rst_flags", 32'({busy_a, ready_a, done_a, q_valid_a, err_a, mask_a}), 0);
    reset = 1'b1;
    tick();

    // ordered: in-order capture and commit
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_busy_after_start", 32'(busy_a), 1);
    cap_a(0, 5'h13);
    chk("a_mask_ch0", 32'(mask_a), 32'h1);
    cap_a(1, 5'h01);
    cap_a(2, 5'h00);
    chk("a_ready", 32'({ready_a, mask_a}), 32'hF);
    exp_a.push_back(15'h0033);
    commit_a = 1'b1; tick(); commit_a = 1'b0;
    chk("a_done_pulse", 32'(done_a), 1);
    chk("a_post_commit", 32'({busy_a, q_valid_a, err_a}), 32'b010);
    tick();
    chk("a_done_one_cycle", 32'(done_a), 0);

    // commit in IDLE ignored
    commit_a = 1'b1; tick(); commit_a = 1'b0; tick();
    chk("a_idle_commit_ign", 32'({done_a, q_a}), 32'h0033);

    // ordered: out-of-order channel flags error and is ignored
    start_a = 1'b1; tick(); start_a = 1'b0;
    cap_a(2, 5'h1F);
    chk("a_ooo_mask", 32'(mask_a), 0);
    chk("a_ooo_err", 32'(err_a), 1);
    cap_a(0, 5'h0C);
    cap_a(1, 5'h0B);
    cap_a(2, 5'h0A);
    exp_a.push_back(15'h296C);
    commit_a = 1'b1; tick(); commit_a = 1'b0;
    chk("a_err_sticky", 32'(err_a), 1);

    // abort mid-capture keeps committed q
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_err_cleared_by_start", 32'(err_a), 0);
    cap_a(0, 5'h01);
    cap_a(1, 5'h02);
    chk("a_mask_two", 32'(mask_a), 32'h3);
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk("a_abort_state", 32'({busy_a, mask_a}), 0);
    chk("a_abort_q", 32'({q_valid_a, q_a}), 32'h0_A96C);

    // abort beats commit in READY
    start_a = 1'b1; tick(); start_a = 1'b0;
    cap_a(0, 5'h1F);
    cap_a(1, 5'h1F);
    cap_a(2, 5'h1F);
    abort_a = 1'b1; commit_a = 1'b1; tick(); abort_a = 1'b0; commit_a = 1'b0;
    chk("a_abort_commit", 32'({busy_a, done_a, q_a}), 32'h296C);

    // unordered: all channels in one cycle, valid in READY ignored
    start_b = 1'b1; tick(); start_b = 1'b0;
    valid_b = 3'b111; din_b = {5'h1F, 5'h0A, 5'h04}; tick(); valid_b = '0;
    chk("b_ready_fast", 32'({ready_b, mask_b, err_b}), 32'b1_111_0);
    valid_b = 3'b111; din_b = '0; tick(); valid_b = '0;
    chk("b_ready_valid_ign", 32'({ready_b, err_b}), 32'b10);
    exp_b.push_back(15'h7D44);
    commit_b = 1'b1; tick(); commit_b = 1'b0;

    // unordered: repeated channel keeps first capture
    start_b = 1'b1; tick(); start_b = 1'b0;
    valid_b = 3'b010; din_b = {5'h00, 5'h0A, 5'h00}; tick();
    valid_b = 3'b011; din_b = {5'h00, 5'h15, 5'h03}; tick();
    chk("b_repeat_err", 32'({err_b, mask_b}), 32'b1_011);
    valid_b = 3'b100; din_b = {5'h11, 5'h00, 5'h00}; tick(); valid_b = '0;
    exp_b.push_back(15'h4543);
    commit_b = 1'b1; tick(); commit_b = 1'b0;
    tick();

    // asynchronous reset in the middle of a capture
    start_a = 1'b1; tick(); start_a = 1'b0;
    cap_a(0, 5'h07);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_a", 32'({q_a, busy_a, ready_a, done_a, q_valid_a, err_a, mask_a}), 0);
    chk("async_rst_b", 32'({q_b, q_valid_b, err_b}), 0);
    chk("a_queue_drained", 32'(exp_a.size()), 0);
    chk("b_queue_drained", 32'(exp_b.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
